// File: rtl/usb_frame_wr_ctrl_pkg.sv
// Shared constants for the USB frame write controller: header fields, frame sizes, FSM states.
package usb_frame_wr_ctrl_pkg;

  localparam logic [15:0] MAGIC     = 16'hA55A;
  localparam int          CA_WORDS  = 32;
  localparam int          MSG_WORDS = 47;
  localparam int          DELAY_W   = 10;
  localparam int          CNT_W     = 6;

  localparam logic [3:0] TYPE_CA    = 4'd1;
  localparam logic [3:0] TYPE_MSG   = 4'd2;
  localparam logic [3:0] TYPE_DELAY = 4'd3;

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/usb_frame_wr_ctrl_hdr_decode.sv
// Combinational frame header check: magic and type validity, plus type/channel extraction.
module frame_hdr_decode
  import usb_frame_wr_ctrl_pkg::*;
(
  input  logic [31:0] hdr_i,
  output logic        valid_o,
  output logic [3:0]  type_o,
  output logic [2:0]  chan_o
);

  // Bits [11:3] are reserved in the header format.
  logic unused_rsvd;
  assign unused_rsvd = ^hdr_i[11:3];

  assign type_o  = hdr_i[15:12];
  assign chan_o  = hdr_i[2:0];
  assign valid_o = (hdr_i[31:16] == MAGIC) &&
                   ((type_o == TYPE_CA) || (type_o == TYPE_MSG) || (type_o == TYPE_DELAY));

endmodule

// File: rtl/usb_frame_wr_ctrl.sv
// Parses framed packets from the USB3 RX FIFO into CA/MSG RAM writes and code-delay registers.
// Optional build macro FRAME_CHECKSUM_EN adds an XOR trailer word and gated delay commit.
module usb_frame_wr_ctrl
  import usb_frame_wr_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [31:0]        data,
  output logic [15:0]        wren,
  output logic [DELAY_W-1:0] delay_ca0,
  output logic [DELAY_W-1:0] delay_ca1,
  output logic [DELAY_W-1:0] delay_ca2,
  output logic [DELAY_W-1:0] delay_ca3,
  output logic [DELAY_W-1:0] delay_ca4,
  output logic [DELAY_W-1:0] delay_ca5,
  output logic [DELAY_W-1:0] delay_ca6,
  output logic [DELAY_W-1:0] delay_ca7,
  output logic               frame_done,
  output logic [7:0]         err_cnt
);

  logic                     ready_q;
  logic [1:0]               state_q, state_d;
  logic [3:0]               typ_q, typ_d;
  logic [2:0]               ch_q, ch_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [31:0]              data_q, data_d;
  logic [15:0]              wren_q, wren_d;
  logic                     done_q, done_d;
  logic [7:0]               err_q, err_d;
  logic [7:0][DELAY_W-1:0]  dly_q, dly_d;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0]              csum_q, csum_d;
  logic [DELAY_W-1:0]       shadow_q, shadow_d;
`endif

  logic       acc;
  logic       hdr_ok;
  logic [3:0] hdr_typ;
  logic [2:0] hdr_ch;
  logic       last_word;

  frame_hdr_decode u_hdr (
    .hdr_i   (in_data),
    .valid_o (hdr_ok),
    .type_o  (hdr_typ),
    .chan_o  (hdr_ch)
  );

  assign acc = in_valid && ready_q;

  // DELAY frames always carry exactly one payload word.
  assign last_word = (typ_q == TYPE_DELAY) ||
                     ((typ_q == TYPE_CA)  && (cnt_q == CNT_W'(CA_WORDS - 1))) ||
                     ((typ_q == TYPE_MSG) && (cnt_q == CNT_W'(MSG_WORDS - 1)));

  always_comb begin
    state_d = state_q;
    typ_d   = typ_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    wren_d  = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    dly_d   = dly_q;
`ifdef FRAME_CHECKSUM_EN
    csum_d   = csum_q;
    shadow_d = shadow_q;
`endif
    case (state_q)
      ST_HUNT: begin
        if (acc) begin
          if (hdr_ok) begin
            typ_d   = hdr_typ;
            ch_d    = hdr_ch;
            cnt_d   = '0;
            state_d = ST_PAYLOAD;
`ifdef FRAME_CHECKSUM_EN
            csum_d  = in_data;
`endif
          end else begin
            err_d = sat_inc8(err_q);
          end
        end
      end
      ST_PAYLOAD: begin
        if (acc) begin
          cnt_d = cnt_q + CNT_W'(1);
`ifdef FRAME_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (typ_q == TYPE_DELAY) begin
`ifdef FRAME_CHECKSUM_EN
            shadow_d = in_data[DELAY_W-1:0];
`else
            dly_d[ch_q] = in_data[DELAY_W-1:0];
`endif
          end else begin
            data_d = in_data;
            wren_d = 16'h0001 << {(typ_q == TYPE_MSG), ch_q};
          end
          if (last_word) begin
`ifdef FRAME_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            done_d  = 1'b1;
            state_d = ST_HUNT;
`endif
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      ST_CHECK: begin
        if (acc) begin
          done_d  = 1'b1;
          state_d = ST_HUNT;
          if (in_data == csum_q) begin
            if (typ_q == TYPE_DELAY) dly_d[ch_q] = shadow_q;
          end else begin
            err_d = sat_inc8(err_q);
          end
        end
      end
`endif
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      state_q  <= ST_HUNT;
      typ_q    <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      wren_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= '0;
      dly_q    <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum_q   <= '0;
      shadow_q <= '0;
`endif
    end else begin
      ready_q  <= 1'b1;
      state_q  <= state_d;
      typ_q    <= typ_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dly_q    <= dly_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q   <= csum_d;
      shadow_q <= shadow_d;
`endif
    end
  end

  assign in_ready   = ready_q;
  assign data       = data_q;
  assign wren       = wren_q;
  assign frame_done = done_q;
  assign err_cnt    = err_q;
  assign delay_ca0  = dly_q[0];
  assign delay_ca1  = dly_q[1];
  assign delay_ca2  = dly_q[2];
  assign delay_ca3  = dly_q[3];
  assign delay_ca4  = dly_q[4];
  assign delay_ca5  = dly_q[5];
  assign delay_ca6  = dly_q[6];
  assign delay_ca7  = dly_q[7];

endmodule

// File: tb/tb_usb_frame_wr_ctrl.sv
// Scoreboard bench for usb_frame_wr_ctrl: stimulus pushes expected write/done events, a monitor pops them.
module tb_usb_frame_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data;
  logic [15:0] wren;
  logic [9:0]  d0, d1, d2, d3, d4, d5, d6, d7;
  logic        frame_done;
  logic [7:0]  err_cnt;

  usb_frame_wr_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data       (data),
    .wren       (wren),
    .delay_ca0  (d0),
    .delay_ca1  (d1),
    .delay_ca2  (d2),
    .delay_ca3  (d3),
    .delay_ca4  (d4),
    .delay_ca5  (d5),
    .delay_ca6  (d6),
    .delay_ca7  (d7),
    .frame_done (frame_done),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] wren;
    logic [31:0] data;
    logic        done;
    logic [79:0] dly;
  } exp_t;

  exp_t        expq[$];
  logic [79:0] mdly = '0;
  logic [7:0]  merr = '0;
  int          checks = 0;
  int          failures = 0;

  wire [79:0] dly_all = {d7, d6, d5, d4, d3, d2, d1, d0};

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write or frame_done cycle must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && (wren != 16'h0 || frame_done)) begin
      if (expq.size() == 0) begin
        check("unexpected_event", {63'd0, frame_done, wren, data}, 96'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("wren", 96'(wren), 96'(e.wren));
        if (e.wren != 16'h0) check("data", 96'(data), 96'(e.data));
        check("frame_done", 96'(frame_done), 96'(e.done));
        check("delays", 96'(dly_all), 96'(e.dly));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 96'(in_ready), 96'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [15:0] w, input logic [31:0] d, input logic done);
    exp_t e;
    e.wren = w;
    e.data = d;
    e.done = done;
    e.dly  = mdly;
    expq.push_back(e);
  endtask

  // Sends header plus the first 'stop' of 'n' payload words base, base+1, ...
  task automatic frame(input logic [31:0] hdr, input int n, input int stop,
                       input logic [31:0] base, input logic [15:0] ew, input bit gaps);
    logic [31:0] cs, w;
    cs = hdr;
    send(hdr);
    for (int i = 0; i < stop; i++) begin
      w  = base + 32'(i);
      cs = cs ^ w;
`ifdef FRAME_CHECKSUM_EN
      push(ew, w, 1'b0);
`else
      push(ew, w, i == n - 1);
`endif
      send(w);
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
`ifdef FRAME_CHECKSUM_EN
    if (stop == n) begin
      push(16'h0, 32'h0, 1'b1);
      send(cs);
    end
`endif
  endtask

  task automatic delay_frame(input logic [31:0] hdr, input int ch, input logic [31:0] val, input bit bad);
    send(hdr);
`ifdef FRAME_CHECKSUM_EN
    send(val);
    if (bad) merr = (merr == 8'hFF) ? merr : merr + 8'd1;
    else     mdly[ch*10 +: 10] = val[9:0];
    push(16'h0, 32'h0, 1'b1);
    send(bad ? ~(hdr ^ val) : (hdr ^ val));
`else
    mdly[ch*10 +: 10] = val[9:0];
    push(16'h0, 32'h0, 1'b1);
    send(val);
`endif
  endtask

  initial begin
    // Reset state
    #22;
    check("rst_in_ready", 96'(in_ready), 96'd0);
    check("rst_wren", 96'(wren), 96'd0);
    check("rst_data", 96'(data), 96'd0);
    check("rst_done", 96'(frame_done), 96'd0);
    check("rst_err", 96'(err_cnt), 96'd0);
    check("rst_delays", 96'(dly_all), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 96'(in_ready), 96'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 96'(in_ready), 96'd1);

    // CA frame ch3, data 0..31
    frame(32'hA55A_1003, 32, 32, 32'h0, 16'h0008, 1'b0);
    idle(2);
    check("ca_err", 96'(err_cnt), 96'(merr));

    // MSG frame ch7 with random gaps, back-to-back after previous idle
    frame(32'hA55A_2007, 47, 47, 32'hC000_0000, 16'h8000, 1'b1);
    idle(2);

    // DELAY frames: ch2 <- 1023, then ch5 <- 0x155 with upper bits ignored
    delay_frame(32'hA55A_3002, 2, 32'h0000_03FF, 1'b0);
    idle(1);
    check("delay_ca2", 96'(d2), 96'd1023);
    delay_frame(32'hA55A_3005, 5, 32'hFFFF_F155, 1'b0);
    idle(1);
    check("delay_ca5", 96'(d5), 96'h155);
    check("delay_ca2_kept", 96'(d2), 96'd1023);

    // Garbage: bad magic, then bad type
    send(32'h1234_1003);
    send(32'hA55A_5000);
    merr = 8'd2;
    idle(1);
    check("garbage_err", 96'(err_cnt), 96'd2);
    frame(32'hA55A_1000, 32, 32, 32'h0000_0A00, 16'h0001, 1'b0);
    idle(2);
    check("post_garbage_err", 96'(err_cnt), 96'(merr));

`ifdef FRAME_CHECKSUM_EN
    delay_frame(32'hA55A_3001, 1, 32'h0000_0123, 1'b1);
    idle(1);
    check("csum_bad_delay", 96'(d1), 96'd0);
    check("csum_bad_err", 96'(err_cnt), 96'(merr));
    delay_frame(32'hA55A_3001, 1, 32'h0000_0123, 1'b0);
    idle(1);
    check("csum_good_delay", 96'(d1), 96'h123);
`endif

    // Reset mid-frame after 10 CA payload words
    frame(32'hA55A_1003, 32, 10, 32'h0000_0500, 16'h0008, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_wren", 96'(wren), 96'd0);
    check("midrst_done", 96'(frame_done), 96'd0);
    check("midrst_ready", 96'(in_ready), 96'd0);
    check("midrst_queue", 96'(expq.size()), 96'd0);
    mdly = '0;
    merr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_err", 96'(err_cnt), 96'd0);
    frame(32'hA55A_1003, 32, 32, 32'h0000_0700, 16'h0008, 1'b0);
    idle(3);

    check("queue_empty", 96'(expq.size()), 96'd0);
    check("final_err", 96'(err_cnt), 96'(merr));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
